// File: rtl/btn_ctrl_if.sv
// Button controller bus: raw buttons in, debounced levels/strobes and LED settings out.
// Latency: none, this is wiring only.
// Backpressure: none; o_valid is an unacknowledged one-cycle strobe.
interface btn_ctrl_if #(
    parameter int NB_BTN   = 4,
    parameter int NB_SPEED = 3
);
    logic [NB_BTN-1:0]   i_btn;
    logic [NB_BTN-1:0]   o_btn_level;
    logic [NB_BTN-1:0]   o_btn_pulse;
    logic [NB_SPEED-1:0] o_speed;
    logic                o_dir;
    logic                o_color;
    logic                o_valid;

    // Board/stimulus side: drives the raw buttons, observes the settings.
    modport master (
        output i_btn,
        input  o_btn_level, o_btn_pulse, o_speed, o_dir, o_color, o_valid
    );

    // Controller side.
    modport slave (
        input  i_btn,
        output o_btn_level, o_btn_pulse, o_speed, o_dir, o_color, o_valid
    );
endinterface

// File: rtl/btn_ctrl.sv
// Push-button controller: synchronize, debounce, and turn presses into speed/dir/color commands.
// Latency: debounced level/pulse 2+DB_LIMIT cycles after a raw change; settings and o_valid 2 cycles after the pulse.
// Backpressure: none; presses arriving while a command is being applied or buttons are still held are dropped.
module btn_ctrl #(
    parameter int NB_BTN        = 4,
    parameter int NB_DB_COUNTER = 20,
    parameter int DB_LIMIT      = 1000000,
    parameter int NB_SPEED      = 3
) (
    input  logic         clock,
    input  logic         i_reset,
    btn_ctrl_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        APPLY    = 2'd1,
        WAIT_REL = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CMD_UP    = 2'd0,
        CMD_DOWN  = 2'd1,
        CMD_DIR   = 2'd2,
        CMD_COLOR = 2'd3
    } cmd_t;

    localparam logic [NB_DB_COUNTER-1:0] DB_LAST   = NB_DB_COUNTER'(DB_LIMIT - 1);
    localparam logic [NB_SPEED-1:0]      SPEED_MAX = '1;

    logic [NB_BTN-1:0]        r_sync1;
    logic [NB_BTN-1:0]        r_sync2;
    logic [NB_BTN-1:0]        r_level;
    logic [NB_BTN-1:0]        r_pulse;
    logic [NB_DB_COUNTER-1:0] r_cnt [NB_BTN];

    state_t              r_state;
    cmd_t                r_cmd;
    logic [NB_SPEED-1:0] r_speed;
    logic                r_dir;
    logic                r_color;
    logic                r_valid;

    cmd_t                w_cmd;
    logic                w_any_press;

    // Two-flop synchronizer on the raw asynchronous button levels.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= bus.i_btn;
            r_sync2 <= r_sync1;
        end
    end

    // Per-button debounce: accept a new level after DB_LIMIT consecutive differing cycles;
    // the press strobe is registered alongside the level so both appear in the same cycle.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            r_level <= '0;
            r_pulse <= '0;
            for (int i = 0; i < NB_BTN; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NB_BTN; i++) begin
                if (r_sync2[i] == r_level[i]) begin
                    r_cnt[i]   <= '0;
                    r_pulse[i] <= 1'b0;
                end else if (r_cnt[i] == DB_LAST) begin
                    r_level[i] <= r_sync2[i];
                    r_cnt[i]   <= '0;
                    r_pulse[i] <= r_sync2[i];
                end else begin
                    r_cnt[i]   <= r_cnt[i] + 1'b1;
                    r_pulse[i] <= 1'b0;
                end
            end
        end
    end

    // Fixed-priority pick among simultaneous presses: speed up beats down beats dir beats color.
    always_comb begin
        w_any_press = |r_pulse[3:0];
        w_cmd       = CMD_COLOR;
        if (r_pulse[0]) begin
            w_cmd = CMD_UP;
        end else if (r_pulse[1]) begin
            w_cmd = CMD_DOWN;
        end else if (r_pulse[2]) begin
            w_cmd = CMD_DIR;
        end
    end

    // Command FSM: latch one command per press session, apply it for one cycle,
    // then ignore everything until all buttons are released.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_cmd   <= CMD_UP;
            r_speed <= '0;
            r_dir   <= 1'b0;
            r_color <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any_press) begin
                        r_cmd   <= w_cmd;
                        r_state <= APPLY;
                    end
                end
                APPLY: begin
                    case (r_cmd)
                        CMD_UP: begin
                            // Saturated speed commands are swallowed silently.
                            if (r_speed != SPEED_MAX) begin
                                r_speed <= r_speed + 1'b1;
                                r_valid <= 1'b1;
                            end
                        end
                        CMD_DOWN: begin
                            if (r_speed != '0) begin
                                r_speed <= r_speed - 1'b1;
                                r_valid <= 1'b1;
                            end
                        end
                        CMD_DIR: begin
                            r_dir   <= ~r_dir;
                            r_valid <= 1'b1;
                        end
                        default: begin
                            r_color <= ~r_color;
                            r_valid <= 1'b1;
                        end
                    endcase
                    r_state <= WAIT_REL;
                end
                WAIT_REL: begin
                    if (r_level == '0) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_btn_level = r_level;
    assign bus.o_btn_pulse = r_pulse;
    assign bus.o_speed     = r_speed;
    assign bus.o_dir       = r_dir;
    assign bus.o_color     = r_color;
    assign bus.o_valid     = r_valid;

endmodule

// File: doc/btn_ctrl.md
BTN_CTRL -- requirements
Module: btn_ctrl

Interface
REQ-001 Parameter NB_BTN, default 4, SHALL set the number of push-button inputs; bit 0 is speed up, bit 1 speed down, bit 2 direction toggle, bit 3 color toggle.
REQ-002 Parameter NB_DB_COUNTER, default 20, SHALL set the width of each per-button debounce counter.
REQ-003 Parameter DB_LIMIT, default 1000000, SHALL set the number of consecutive clocks a changed input must hold before it is accepted.
REQ-004 Parameter NB_SPEED, default 3, SHALL set the width of the speed setting.
REQ-005 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 i_reset  input  1  SHALL be the reset, synchronous and active-high.
REQ-007 i_btn  input  NB_BTN  SHALL carry raw, asynchronous, active-high button levels.
REQ-008 o_btn_level  output  NB_BTN  SHALL carry the debounced button levels.
REQ-009 o_btn_pulse  output  NB_BTN  SHALL carry a one-cycle press strobe per button.
REQ-010 o_speed  output  NB_SPEED  SHALL carry the speed-select setting driven to the LED step counter.
REQ-011 o_dir  output  1  SHALL carry the shift direction (0 = left, 1 = right).
REQ-012 o_color  output  1  SHALL carry the LED color select (0 = blue, 1 = green).
REQ-013 o_valid  output  1  SHALL pulse high for one cycle whenever o_speed, o_dir or o_color changes.

Function
REQ-014 Each i_btn bit SHALL pass through a two-flop synchronizer; a raw change before edge k SHALL appear at the synchronizer output after edge k+1.
REQ-015 Each button SHALL have a debounce counter that clears whenever the synchronizer output equals the debounced level.
REQ-016 While the synchronizer output differs from the debounced level, the counter SHALL increment each cycle.
REQ-017 On the DB_LIMIT-th consecutive differing cycle, o_btn_level SHALL take the synchronizer value and the counter SHALL clear; for a raw change at cycle 0, o_btn_level changes at cycle 2+DB_LIMIT.
REQ-018 o_btn_pulse[i] SHALL be high only in the first cycle in which o_btn_level[i] is 1 after having been 0; releases SHALL produce no pulse.
REQ-019 The command FSM SHALL have the states IDLE, APPLY and WAIT_REL.
REQ-020 In IDLE, any o_btn_pulse bit SHALL latch one command and move the FSM to APPLY on the next edge.
REQ-021 When several pulse bits are high in the same cycle, the command SHALL follow the priority bit0 > bit1 > bit2 > bit3, and only the winning command SHALL be latched.
REQ-022 APPLY SHALL last exactly one cycle; the updated settings and o_valid=1 SHALL be visible in the cycle after APPLY, which is pulse cycle + 2.
REQ-023 After APPLY the FSM SHALL enter WAIT_REL, and SHALL return to IDLE on the edge after o_btn_level is all zeros.
REQ-024 Pulses arriving in APPLY or WAIT_REL SHALL be discarded, giving one command per press session.
REQ-025 Speed up SHALL add 1 to o_speed and saturate at 2^NB_SPEED-1; speed down SHALL subtract 1 and saturate at 0; neither SHALL wrap.
REQ-026 A speed command at saturation SHALL leave o_speed unchanged and SHALL NOT assert o_valid, while the FSM still passes through APPLY and WAIT_REL.
REQ-027 The direction and color commands SHALL invert o_dir and o_color respectively, and SHALL always assert o_valid.
REQ-028 o_valid SHALL never be high for two consecutive cycles.

Reset
REQ-029 While i_reset=1 at an edge, the block SHALL clear the synchronizer flops, debounce counters and o_btn_level.
REQ-030 While i_reset=1 at an edge, the block SHALL also set o_btn_pulse=0, o_valid=0, o_speed=0, o_dir=0, o_color=0 and FSM=IDLE.
REQ-031 Reset asserted mid-debounce or mid-FSM SHALL abort the operation, and no command SHALL be applied.
REQ-032 A button held through reset release SHALL be treated as a new press and SHALL be accepted after 2+DB_LIMIT cycles.

Verification (bench uses DB_LIMIT=4, NB_SPEED=3)
REQ-033 Rise i_btn[0] at cycle 0 and hold -> o_btn_level[0]=1 and o_btn_pulse[0]=1 at cycle 6; o_speed=1 and o_valid=1 at cycle 8.
REQ-034 Pulse i_btn[2] high for 3 cycles only -> o_btn_level stays 0, no pulse, o_dir unchanged.
REQ-035 Apply 9 speed-up press sessions -> o_speed sequence 1..7 then holds at 7; o_valid is absent on sessions 8 and 9.
REQ-036 Raise i_btn[1] and i_btn[3] in the same cycle -> only the speed-down command applies; o_color is unchanged; from speed 0, o_valid stays 0.
REQ-037 Hold i_btn[3] and press i_btn[2] during WAIT_REL -> o_dir is unchanged; after both are released, the next i_btn[2] press toggles o_dir.
REQ-038 Assert i_reset during APPLY -> the next cycle shows all outputs 0 and FSM=IDLE, with no o_valid pulse.
